// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and clear-sequencer state encoding for ram_sp_param.
package ram_pkg;
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } clr_state_e;
endpackage

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: post-reset sequencer that walks every address writing zero.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);
    localparam int DEPTH = 2 ** ADDR_W;
    clr_state_e r_state;
    logic [ADDR_W:0] r_cnt;
    logic r_busy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
                    r_busy  <= (CLEAR_ON_RESET != 0);
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    // busy drops together with the final zero write
                    if (r_cnt == (ADDR_W+1)'(DEPTH - 1)) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end
    assign o_busy     = r_busy;
    assign o_clr_we   = (r_state == ST_CLEAR);
    assign o_clr_addr = r_cnt[ADDR_W-1:0];
endmodule

// File: rtl/ram_sp_param.sv
// ram_sp_param: parametrised single-port RAM with byte enables, RDW mode,
// optional output register and a post-reset clear sequencer.
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 6,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    output logic [DATA_W-1:0]   q,
    output logic                q_valid,
    output logic                busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q1;
    logic              r_v1;
    logic              w_busy, w_clr_we, w_acc, w_wr, w_rd_v;
    logic [ADDR_W-1:0] w_clr_addr, w_addr;
    logic [DATA_W-1:0] w_old, w_merged, w_wdata, w_rd_data;

    ram_clear_fsm #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_acc = en & ~w_busy;
    assign w_old = r_mem[addr];
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign w_merged[8*i +: 8] = be[i] ? data[8*i +: 8] : w_old[8*i +: 8];
    end
    // the clear sequencer owns the port while it runs
    assign w_addr  = w_clr_we ? w_clr_addr : addr;
    assign w_wdata = w_clr_we ? '0 : w_merged;
    assign w_wr    = w_clr_we | (w_acc & we);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_addr] <= w_wdata;
    end

    assign w_rd_data = (we && RDW_MODE == RDW_WRITE_FIRST) ? w_merged : w_old;
    assign w_rd_v    = w_acc & ~(we && RDW_MODE == RDW_NO_CHANGE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_v;
            if (w_rd_v) r_q1 <= w_rd_data;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] r_q2;
        logic              r_v2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q2 <= '0;
                r_v2 <= 1'b0;
            end else begin
                r_q2 <= r_q1;
                r_v2 <= r_v1;
            end
        end
        assign q       = r_q2;
        assign q_valid = r_v2;
    end else begin : g_nreg
        assign q       = r_q1;
        assign q_valid = r_v1;
    end

    assign busy = w_busy;
endmodule

// File: tb/tb_ram_sp_param.sv
// tb_ram_sp_param: five RAM variants driven in lockstep, checked against a
// behavioural memory model through per-variant scoreboards with due cycles.
module tb_ram_sp_param;
    import ram_pkg::*;
    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, we = 1'b0, be1 = 1'b0;
    logic [5:0]  addr = '0;
    logic [7:0]  d8 = '0;
    logic [31:0] d32 = '0;
    logic [3:0]  be4 = '0;
    logic [7:0]  q0, q1, q2, q3;
    logic [31:0] q4;
    logic [4:0]  qv, bz;
    int ncmp = 0, nfail = 0, cyc = 0;
    exp_t sb[5][$];
    logic [7:0]  m8 [64];
    logic [31:0] m32 [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_sp_param u0 (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be1), .addr(addr),
                     .data(d8), .q(q0), .q_valid(qv[0]), .busy(bz[0]));
    ram_sp_param #(.RDW_MODE(RDW_WRITE_FIRST)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .we(we),
                     .be(be1), .addr(addr), .data(d8), .q(q1), .q_valid(qv[1]), .busy(bz[1]));
    ram_sp_param #(.RDW_MODE(RDW_NO_CHANGE)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .we(we),
                     .be(be1), .addr(addr), .data(d8), .q(q2), .q_valid(qv[2]), .busy(bz[2]));
    ram_sp_param #(.OUT_REG(1)) u3 (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be1),
                     .addr(addr), .data(d8), .q(q3), .q_valid(qv[3]), .busy(bz[3]));
    ram_sp_param #(.DATA_W(32)) u4 (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be4),
                     .addr(addr), .data(d32), .q(q4), .q_valid(qv[4]), .busy(bz[4]));

    function automatic logic [31:0] qo(input int k);
        return k == 0 ? {24'b0, q0} : k == 1 ? {24'b0, q1} : k == 2 ? {24'b0, q2} :
               k == 3 ? {24'b0, q3} : q4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 5; k++) begin
                if (qv[k]) begin
                    if (sb[k].size() == 0) check($sformatf("unexpected_valid_u%0d", k), {31'b0, qv[k]}, 32'd0);
                    else begin
                        e = sb[k].pop_front();
                        check($sformatf("q_u%0d", k), qo(k), e.d);
                        check($sformatf("latency_u%0d", k), cyc, e.due);
                    end
                end else if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
                    check($sformatf("missing_valid_u%0d", k), {31'b0, qv[k]}, 32'd1);
                    void'(sb[k].pop_front());
                end
            end
        end
    end

    task automatic acc(input logic w, input logic [5:0] a, input logic [7:0] v8, input logic b8,
                       input logic [31:0] v32, input logic [3:0] b32);
        logic [7:0]  o8, n8;
        logic [31:0] o32, n32;
        @(negedge clk);
        en = 1'b1; we = w; addr = a; d8 = v8; be1 = b8; d32 = v32; be4 = b32;
        o8  = m8[a];
        n8  = b8 ? v8 : o8;
        o32 = m32[a];
        for (int i = 0; i < 4; i++) n32[8*i +: 8] = b32[i] ? v32[8*i +: 8] : o32[8*i +: 8];
        sb[0].push_back('{d: {24'b0, o8}, due: cyc + 1});
        sb[1].push_back('{d: {24'b0, w ? n8 : o8}, due: cyc + 1});
        if (!w) sb[2].push_back('{d: {24'b0, o8}, due: cyc + 1});
        sb[3].push_back('{d: {24'b0, o8}, due: cyc + 2});
        sb[4].push_back('{d: o32, due: cyc + 1});
        if (w) begin
            m8[a]  = n8;
            m32[a] = n32;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0; we = 1'b0;
        end
    endtask

    task automatic count_clear(input string tag, input bit drop);
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (drop && n == 30) begin
                en = 1'b1; we = 1'b1; addr = 6'd10; d8 = 8'hFF; be1 = 1'b1; d32 = '1; be4 = '1;
            end else en = 1'b0;
        end while (bz[0] && n < 200);
        check(tag, n, 32'd65);
        check({tag, "_busy_all"}, {27'b0, bz}, 32'd0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            m8[i]  = '0;
            m32[i] = '0;
        end
    endtask

    task automatic sb_empty(input string tag);
        for (int k = 0; k < 5; k++) check($sformatf("%s_u%0d", tag, k), sb[k].size(), 32'd0);
    endtask

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_busy", {27'b0, bz}, 32'h1F);
        check("rst_qv", {27'b0, qv}, 32'd0);
        for (int k = 0; k < 5; k++) check($sformatf("rst_q_u%0d", k), qo(k), 32'd0);
        count_clear("clear_len", 1'b1);
        for (int a = 0; a < 64; a++) acc(1'b0, 6'(a), 8'h00, 1'b0, 32'h0, 4'h0);
        idle(3);
        acc(1'b1, 6'd5,  8'hAA, 1'b1, 32'hA5A5_A5A5, 4'hF);
        acc(1'b1, 6'd25, 8'h55, 1'b1, 32'h0102_0304, 4'hF);
        acc(1'b1, 6'd55, 8'h45, 1'b1, 32'hCAFE_F00D, 4'h3);
        acc(1'b1, 6'd3,  8'h12, 1'b1, 32'hDEAD_BEEF, 4'hF);
        acc(1'b1, 6'd3,  8'h34, 1'b0, 32'h1122_3344, 4'b0101);
        acc(1'b0, 6'd3,  8'h00, 1'b0, 32'h0, 4'h0);
        acc(1'b0, 6'd10, 8'h00, 1'b0, 32'h0, 4'h0);
        idle(1);
        acc(1'b1, 6'd5,  8'h55, 1'b1, 32'h5555_5555, 4'hF);
        acc(1'b0, 6'd5,  8'h00, 1'b0, 32'h0, 4'h0);
        acc(1'b1, 6'd5,  8'hAA, 1'b1, 32'hAAAA_AAAA, 4'hF);
        acc(1'b0, 6'd5,  8'h00, 1'b0, 32'h0, 4'h0);
        acc(1'b0, 6'd25, 8'h00, 1'b0, 32'h0, 4'h0);
        acc(1'b0, 6'd55, 8'h00, 1'b0, 32'h0, 4'h0);
        idle(4);
        sb_empty("drain");
        acc(1'b0, 6'd25, 8'h00, 1'b0, 32'h0, 4'h0);
        acc(1'b0, 6'd55, 8'h00, 1'b0, 32'h0, 4'h0);
        en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midpipe_q3", {24'b0, q3}, 32'd0);
        check("midpipe_qv", {27'b0, qv}, 32'd0);
        for (int k = 0; k < 5; k++) sb[k].delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("midclear_busy", {27'b0, bz}, 32'h1F);
        count_clear("clear_restart", 1'b0);
        clear_model();
        acc(1'b0, 6'd5,  8'h00, 1'b0, 32'h0, 4'h0);
        acc(1'b0, 6'd55, 8'h00, 1'b0, 32'h0, 4'h0);
        idle(4);
        sb_empty("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
